// File: rtl/vga_pkg.sv
// Shared display geometry and colour constants for the pong pixel generator.
// Coordinates are plain integers; each consumer widens them to its own compare width.
package vga_pkg;

    localparam int H_DISPLAY    = 640;
    localparam int V_DISPLAY    = 480;
    localparam int FRAME_TICK_Y = V_DISPLAY + 1;

    localparam int WALL_X_L   = 32;
    localparam int WALL_X_R   = 35;
    localparam int PAD_X_L    = 600;
    localparam int PAD_X_R    = 603;
    localparam int PAD_Y_INIT = 204;
    localparam int SPAWN_X    = 320;
    localparam int SPAWN_Y    = 240;

    localparam logic [11:0] COLOR_BALL = 12'hF80;
    localparam logic [11:0] COLOR_PAD  = 12'h0F0;
    localparam logic [11:0] COLOR_WALL = 12'h00F;
    localparam logic [11:0] COLOR_BG   = 12'h000;

    typedef enum logic [1:0] {
        OBJ_NONE,
        OBJ_WALL,
        OBJ_PAD,
        OBJ_BALL
    } obj_e;

endpackage

// File: rtl/pong_motion.sv
// Per-frame motion engine: detects the blanking-time frame tick and advances
// the paddle, the bouncing ball and the miss counter exactly once per frame.
module pong_motion #(
    parameter int BALL_SIZE = 8,
    parameter int BALL_V    = 2,
    parameter int PAD_H     = 72,
    parameter int PAD_V     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       frame_tick,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle_y,
    output logic [3:0] miss_count
);
    import vga_pkg::*;

    localparam logic [10:0] BS            = 11'(BALL_SIZE);
    localparam logic [10:0] BV            = 11'(BALL_V);
    localparam logic [10:0] PH            = 11'(PAD_H);
    localparam logic [10:0] PV            = 11'(PAD_V);
    localparam logic [10:0] PAD_Y_MAX     = 11'(V_DISPLAY - PAD_H - PAD_V);
    localparam logic [10:0] BALL_Y_MAX    = 11'(V_DISPLAY - BALL_SIZE - BALL_V);
    localparam logic [10:0] WALL_BOUNCE_X = 11'(WALL_X_R + 1 + BALL_V);
    localparam logic [10:0] HIT_X_LO      = 11'(PAD_X_L - BALL_SIZE - BALL_V + 1);
    localparam logic [10:0] HIT_X_HI      = 11'(PAD_X_L - BALL_SIZE);
    localparam logic [10:0] MISS_X        = 11'(H_DISPLAY - BALL_SIZE);

    logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d, paddle_y_q, paddle_y_d;
    logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [3:0]  miss_count_q, miss_count_d;
    logic [10:0] bx, by, py;

    // Gated by reset so no update can be requested while state is being cleared.
    assign frame_tick = p_tick && (x == 10'd0) && (y == 10'(FRAME_TICK_Y)) && !reset;

    assign bx = {1'b0, ball_x_q};
    assign by = {1'b0, ball_y_q};
    assign py = {1'b0, paddle_y_q};

    always_comb begin
        paddle_y_d   = paddle_y_q;
        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;
        miss_count_d = miss_count_q;

        if (frame_tick) begin
            if (btn_up && !btn_down && (py >= PV)) begin
                paddle_y_d = 10'(py - PV);
            end else if (btn_down && !btn_up && (py <= PAD_Y_MAX)) begin
                paddle_y_d = 10'(py + PV);
            end

            // A miss overrides every other x rule and leaves the vertical direction alone.
            if (bx >= MISS_X) begin
                ball_x_d     = 10'(SPAWN_X);
                ball_y_d     = 10'(SPAWN_Y);
                dir_x_d      = 1'b0;
                miss_count_d = miss_count_q + 4'd1;
            end else begin
                if (by < BV) begin
                    dir_y_d = 1'b1;
                end
                if (by > BALL_Y_MAX) begin
                    dir_y_d = 1'b0;
                end
                if (bx < WALL_BOUNCE_X) begin
                    dir_x_d = 1'b1;
                end
                if (dir_x_q && (bx >= HIT_X_LO) && (bx <= HIT_X_HI) &&
                    (by + BS - 11'd1 >= py) && (by <= py + PH - 11'd1)) begin
                    dir_x_d = 1'b0;
                end
                ball_x_d = dir_x_d ? 10'(bx + BV) : 10'(bx - BV);
                ball_y_d = dir_y_d ? 10'(by + BV) : 10'(by - BV);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ball_x_q     <= 10'(SPAWN_X);
            ball_y_q     <= 10'(SPAWN_Y);
            paddle_y_q   <= 10'(PAD_Y_INIT);
            dir_x_q      <= 1'b1;
            dir_y_q      <= 1'b1;
            miss_count_q <= 4'd0;
        end else begin
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            paddle_y_q   <= paddle_y_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign paddle_y   = paddle_y_q;
    assign miss_count = miss_count_q;

endmodule

// File: rtl/vga_pong_graph.sv
// Pong pixel generator: object hit-testing per pixel and a registered RGB output
// that lines up with the sync generator's one-clock-delayed hsync/vsync.
module vga_pong_graph #(
    parameter int BALL_SIZE = 8,
    parameter int BALL_V    = 2,
    parameter int PAD_H     = 72,
    parameter int PAD_V     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [11:0] rgb,
    output logic        frame_tick,
    output logic [3:0]  miss_count
);
    import vga_pkg::*;

    localparam logic [10:0] BS     = 11'(BALL_SIZE);
    localparam logic [10:0] PH     = 11'(PAD_H);
    localparam logic [10:0] WALL_L = 11'(WALL_X_L);
    localparam logic [10:0] WALL_R = 11'(WALL_X_R);
    localparam logic [10:0] PAD_L  = 11'(PAD_X_L);
    localparam logic [10:0] PAD_R  = 11'(PAD_X_R);

    logic [9:0]  ball_x, ball_y, paddle_y;
    logic [10:0] xw, yw, bx, by, py;
    logic        on_wall, on_pad, on_ball;
    obj_e        obj_sel;
    logic [11:0] pix_color;
    logic [11:0] rgb_q, rgb_d;

    pong_motion #(
        .BALL_SIZE(BALL_SIZE),
        .BALL_V   (BALL_V),
        .PAD_H    (PAD_H),
        .PAD_V    (PAD_V)
    ) u_motion (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .x         (x),
        .y         (y),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .frame_tick(frame_tick),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .paddle_y  (paddle_y),
        .miss_count(miss_count)
    );

    assign xw = {1'b0, x};
    assign yw = {1'b0, y};
    assign bx = {1'b0, ball_x};
    assign by = {1'b0, ball_y};
    assign py = {1'b0, paddle_y};

    assign on_wall = (xw >= WALL_L) && (xw <= WALL_R);
    assign on_pad  = (xw >= PAD_L) && (xw <= PAD_R) && (yw >= py) && (yw < py + PH);
    assign on_ball = (xw >= bx) && (xw < bx + BS) && (yw >= by) && (yw < by + BS);

    // Later assignments win, so the ball is drawn on top of everything else.
    always_comb begin
        obj_sel = OBJ_NONE;
        if (on_wall) obj_sel = OBJ_WALL;
        if (on_pad)  obj_sel = OBJ_PAD;
        if (on_ball) obj_sel = OBJ_BALL;

        unique case (obj_sel)
            OBJ_BALL: pix_color = COLOR_BALL;
            OBJ_PAD:  pix_color = COLOR_PAD;
            OBJ_WALL: pix_color = COLOR_WALL;
            default:  pix_color = COLOR_BG;
        endcase

        rgb_d = rgb_q;
        if (p_tick) begin
            rgb_d = video_on ? pix_color : COLOR_BG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= COLOR_BG;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: doc/vga_pong_graph.md
# vga_pong_graph

Pixel generator placed directly downstream of the VGA sync generator. It consumes the pixel tick, video-enable and pixel coordinates, and produces a registered 12-bit RGB value per pixel. The picture is a one-player pong field: a fixed left wall, a button-driven paddle on the right and a bouncing square ball. All object motion is updated once per frame during vertical blanking, and missed balls are counted.

## Interface
Parameters:
- BALL_SIZE, 8: ball edge length in pixels.
- BALL_V, 2: ball step per frame, per axis.
- PAD_H, 72: paddle height in pixels.
- PAD_V, 3: paddle step per frame.

Ports:
- clk  in  1  system clock; the same clock that drives the sync generator.
- reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- p_tick  in  1  pixel tick from the sync generator; high for one clk per pixel.
- video_on  in  1  high while (x,y) is inside the 640x480 display area.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- btn_up  in  1  level input, already debounced; requests paddle up.
- btn_down  in  1  level input, already debounced; requests paddle down.
- rgb  out  12  pixel colour {R[3:0],G[3:0],B[3:0]}, registered.
- frame_tick  out  1  one-clk pulse, once per frame.
- miss_count  out  4  number of missed balls, wraps modulo 16.

## Operation
- Geometry:
  - Wall occupies x 32..35, full height.
  - Paddle occupies x 600..603 and y paddle_y..paddle_y+PAD_H-1.
  - Ball occupies ball_x..ball_x+BALL_SIZE-1 horizontally and ball_y..ball_y+BALL_SIZE-1 vertically.
- State registers: ball_x, ball_y, paddle_y (10 bits each); dir_x, dir_y (1 = right/down); miss_count.
- Reset values:
  - ball_x=320, ball_y=240, dir_x=1, dir_y=1.
  - paddle_y=204, miss_count=0.
  - rgb=0, frame_tick=0.
- frame_tick is asserted in the clk where p_tick=1, x=0 and y=481. All motion updates happen in that same clk edge.
- Paddle update on frame_tick:
  - btn_up alone and paddle_y>=PAD_V: paddle_y-=PAD_V.
  - btn_down alone and paddle_y<=480-PAD_H-PAD_V (405): paddle_y+=PAD_V.
  - Both pressed or neither pressed: hold.
- Ball update on frame_tick. Direction is resolved from the current position first, then the ball moves one BALL_V step along the new direction.
  - y: if ball_y<BALL_V then dir_y=1. If ball_y>480-BALL_SIZE-BALL_V (470) then dir_y=0.
  - x, wall: if ball_x<36+BALL_V (38) then dir_x=1.
  - x, paddle hit: requires ball_x in 591..592, dir_x=1, ball_y+BALL_SIZE-1>=paddle_y and ball_y<=paddle_y+PAD_H-1. On a hit, dir_x=0.
  - Miss: if ball_x>=640-BALL_SIZE (632), respawn the ball at (320,240) with dir_x=0 and dir_y unchanged, and increment miss_count. Respawn takes priority over every other x rule.
- Rendering, evaluated on p_tick:
  - If video_on=0, rgb<=0.
  - Otherwise pick by priority: ball 12'hF80, then paddle 12'h0F0, then wall 12'h00F, else background 12'h000.
  - When p_tick=0, rgb holds its value.
- All comparisons use unsigned arithmetic widened to 11 bits so that sums cannot wrap.

## Timing
- rgb latency: the colour for pixel (x,y) appears on rgb one clk after the p_tick cycle that presented (x,y). This matches the one-clk register delay the sync generator applies to hsync/vsync.
- frame_tick falls during vertical blanking (y=481), so position changes never tear a visible frame. Every visible frame is drawn from a single consistent state.
- Button inputs are sampled only on the frame_tick clk.
- Reset asserted mid-frame: all state returns to its reset values on the next clk edge. rgb=0 while reset is high. Rendering resumes from the incoming x/y with no resynchronisation required.

## Structure
- Shared package vga_pkg holds:
  - H_DISPLAY=640, V_DISPLAY=480.
  - Wall, paddle and spawn coordinates.
  - The four colour constants.
- One sub-module, pong_motion: owns frame_tick detection, the ball/paddle registers and miss_count, and exports positions. The top level holds only the render comparators and the rgb register.

## Test plan
- Drive reset, then x=324,y=244,video_on=1,p_tick=1 -> next clk rgb=12'hF80. With x=33 -> rgb=12'h00F.
- Hold btn_up for 80 frames -> paddle_y reaches 0 after 68 frames and stays 0. Then hold btn_down for 200 frames -> paddle_y stays at 408.
- Start with ball at y=470, dir_y=1 -> after one frame ball_y=472, after the next ball_y=470, and dir_y=0.
- Ball reaches x=592 overlapping the paddle -> dir_x=0, ball_x=590 next frame, miss_count unchanged.
- Paddle at y=0, ball at y=240 heading right -> ball passes 592 and reaches 632, respawns at (320,240) with dir_x=0, and miss_count increments to 1. Sixteen misses wrap miss_count to 0.
- Assert reset during the visible region (y=100) -> next clk ball=(320,240), paddle_y=204, rgb=0, frame_tick low.
